// File: rtl/lsu_pkg.sv
// Shared types and funct3 codes for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_WAIT_R = 2'd2,
      ST_DONE   = 2'd3
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store strobes and replication, load lane extraction and
// sign/zero extension, and misalignment detection. Purely combinational.
module lsu_align
   import lsu_pkg::*;
(
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        misaligned_o
);

   logic [31:0] rd_shift;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   assign rd_shift = rdata_i >> {addr_lo_i, 3'b000};
   assign rd_byte  = rd_shift[7:0];
   assign rd_half  = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      wstrb_o      = 4'b1111;
      wdata_o      = wdata_i;
      rdata_o      = rdata_i;
      misaligned_o = 1'b0;
      case (funct3_i)
         F3_B, F3_BU: begin
            wstrb_o = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = funct3_i[2] ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
         end
         F3_H, F3_HU: begin
            wstrb_o      = 4'b0011 << {addr_lo_i[1], 1'b0};
            wdata_o      = {2{wdata_i[15:0]}};
            rdata_o      = funct3_i[2] ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            misaligned_o = addr_lo_i[0];
         end
         // F3_W and the undefined codes all behave as a full word.
         default: misaligned_o = |addr_lo_i;
      endcase
      if (!we_i) wstrb_o = 4'b0000;
   end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit bridging the execute stage to a valid/ready +
// rvalid data bus. Define MISALIGN_TRAP_EN to skip the bus on misaligned accesses.
module load_store_unit
   import lsu_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        stall_o,
   output logic        done_o,
   output logic        misaligned_o,
   output logic        bus_valid_o,
   input  logic        bus_ready_i,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_wstrb_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i
);

`ifdef MISALIGN_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   lsu_state_e  state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] rdata_q, rdata_d;
   logic        misaligned_q, misaligned_d;

   logic        in_idle;
   logic [3:0]  al_wstrb;
   logic [31:0] al_wdata;
   logic [31:0] al_rdata;
   logic        al_misaligned;
   logic        trap;

   // One aligner serves both paths: live inputs while IDLE, latched fields afterwards.
   assign in_idle = (state_q == ST_IDLE);

   lsu_align u_align (
      .we_i         (in_idle ? we_i : we_q),
      .funct3_i     (in_idle ? funct3_i : funct3_q),
      .addr_lo_i    (in_idle ? addr_i[1:0] : addr_q[1:0]),
      .wdata_i      (wdata_i),
      .rdata_i      (bus_rdata_i),
      .wstrb_o      (al_wstrb),
      .wdata_o      (al_wdata),
      .rdata_o      (al_rdata),
      .misaligned_o (al_misaligned)
   );

   assign trap = TRAP_EN & al_misaligned;

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      funct3_d     = funct3_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      rdata_d      = rdata_q;
      misaligned_d = misaligned_q;
      case (state_q)
         ST_IDLE: if (req_i) begin
            we_d         = we_i;
            funct3_d     = funct3_i;
            addr_d       = addr_i;
            wdata_d      = al_wdata;
            wstrb_d      = al_wstrb;
            misaligned_d = trap;
            if (trap) begin
               rdata_d = 32'h0;
               state_d = ST_DONE;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: if (bus_ready_i) state_d = we_q ? ST_DONE : ST_WAIT_R;
         ST_WAIT_R: if (bus_rvalid_i) begin
            rdata_d = al_rdata;
            state_d = ST_DONE;
         end
         default: begin
            misaligned_d = 1'b0;
            state_d      = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         we_q         <= 1'b0;
         funct3_q     <= 3'b000;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         wstrb_q      <= 4'b0000;
         rdata_q      <= 32'h0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         funct3_q     <= funct3_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         rdata_q      <= rdata_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign done_o       = (state_q == ST_DONE);
   assign stall_o      = req_i & (state_q != ST_DONE);
   assign misaligned_o = misaligned_q;
   assign rdata_o      = rdata_q;
   assign bus_valid_o  = (state_q == ST_REQ);
   assign bus_we_o     = we_q;
   assign bus_addr_o   = {addr_q[31:2], 2'b00};
   assign bus_wstrb_o  = wstrb_q;
   assign bus_wdata_o  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a delay-configurable
// bus responder; expectations follow the build's MISALIGN_TRAP_EN setting.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_i, we_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i, wdata_i;
   logic [31:0] rdata_o;
   logic        stall_o, done_o, misaligned_o;
   logic        bus_valid_o, bus_ready_i, bus_we_o;
   logic [31:0] bus_addr_o, bus_wdata_o;
   logic [3:0]  bus_wstrb_o;
   logic        bus_rvalid_i;
   logic [31:0] bus_rdata_i;

   int checks   = 0;
   int failures = 0;

   int          dc, hs;
   logic [31:0] ha, hwd, res;
   logic [3:0]  hst;
   logic        hwe, mis;

   load_store_unit dut (
      .clock        (clock),
      .reset        (reset),
      .req_i        (req_i),
      .we_i         (we_i),
      .funct3_i     (funct3_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .rdata_o      (rdata_o),
      .stall_o      (stall_o),
      .done_o       (done_o),
      .misaligned_o (misaligned_o),
      .bus_valid_o  (bus_valid_o),
      .bus_ready_i  (bus_ready_i),
      .bus_we_o     (bus_we_o),
      .bus_addr_o   (bus_addr_o),
      .bus_wstrb_o  (bus_wstrb_o),
      .bus_wdata_o  (bus_wdata_o),
      .bus_rvalid_i (bus_rvalid_i),
      .bus_rdata_i  (bus_rdata_i)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Runs one memory op from its IDLE cycle; returns at the following negedge (+1).
   task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int rdy_dly, input int rv_dly);
      int cyc = 0;
      int rc = 0;
      int vc = 0;
      logic pend = 1'b0;
      req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wd;
      bus_rdata_i = rd; bus_ready_i = 1'b0; bus_rvalid_i = 1'b0;
      dc = 0; hs = 0; ha = 'x; hwd = 'x; hst = 'x; hwe = 'x; res = 'x; mis = 'x;
      while (dc == 0 && cyc < 64) begin
         #1;
         cyc++;
         if (done_o) begin
            dc  = cyc;
            res = rdata_o;
            mis = misaligned_o;
            check("stall_in_done", stall_o, 1'b0);
         end else begin
            check("stall_busy", stall_o, 1'b1);
         end
         if (bus_valid_o) check("req_addr_stable", bus_addr_o, {addr[31:2], 2'b00});
         bus_ready_i = bus_valid_o && (rc >= rdy_dly);
         if (bus_valid_o) rc++;
         bus_rvalid_i = pend && (vc >= rv_dly);
         if (pend) vc++;
         if (bus_valid_o && bus_ready_i) begin
            hs++;
            ha = bus_addr_o; hwd = bus_wdata_o; hst = bus_wstrb_o; hwe = bus_we_o;
            pend = !we;
         end
         @(negedge clock);
      end
      bus_ready_i = 1'b0; bus_rvalid_i = 1'b0;
      check("done_seen", (dc != 0), 1'b1);
      #1;
      check("done_single_pulse", done_o, 1'b0);
   endtask

   initial begin
      reset = 1'b1; req_i = 1'b0; we_i = 1'b0; funct3_i = 3'b000;
      addr_i = 32'h0; wdata_i = 32'h0; bus_ready_i = 1'b0;
      bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
      @(negedge clock); @(negedge clock);
      reset = 1'b0;
      #1;
      check("rst_valid", bus_valid_o, 1'b0);
      check("rst_done", done_o, 1'b0);
      check("rst_rdata", rdata_o, 32'h0);
      check("rst_mis", misaligned_o, 1'b0);
      check("rst_wstrb", bus_wstrb_o, 4'b0000);
      check("rst_stall", stall_o, 1'b0);
      check("rst_addr", bus_addr_o, 32'h0);

      // SB 0x103: lane 3, byte replicated
      run_op(1'b1, F3_B, 32'h103, 32'h000000A5, 32'h0, 0, 0);
      check("sb_addr", ha, 32'h100);
      check("sb_wstrb", hst, 4'b1000);
      check("sb_wdata", hwd, 32'hA5A5A5A5);
      check("sb_we", hwe, 1'b1);
      check("sb_cycles", dc, 3);
      check("sb_hs", hs, 1);

      run_op(1'b0, F3_B, 32'h102, 32'h0, 32'h1280FF00, 0, 0);
      check("lb_data", res, 32'hFFFFFF80);
      check("lb_wstrb", hst, 4'b0000);
      check("lb_we", hwe, 1'b0);
      check("lb_cycles", dc, 4);

      run_op(1'b0, F3_BU, 32'h102, 32'h0, 32'h1280FF00, 0, 0);
      check("lbu_data", res, 32'h00000080);

      // ready held off 3 cycles, rvalid 2 cycles: 4 + 3 + 2
      run_op(1'b0, F3_H, 32'h102, 32'h0, 32'h80017FFF, 3, 2);
      check("lh_data", res, 32'hFFFF8001);
      check("lh_cycles", dc, 9);
      check("lh_hs", hs, 1);

      run_op(1'b0, F3_HU, 32'h100, 32'h0, 32'h80017FFF, 0, 0);
      check("lhu_data", res, 32'h00007FFF);

      run_op(1'b0, F3_W, 32'h200, 32'h0, 32'hDEADBEEF, 1, 0);
      check("lw_data", res, 32'hDEADBEEF);
      check("lw_cycles", dc, 5);

      run_op(1'b1, F3_H, 32'h102, 32'h1234ABCD, 32'h0, 0, 0);
      check("sh_wstrb", hst, 4'b1100);
      check("sh_wdata", hwd, 32'hABCDABCD);
      check("sh_addr", ha, 32'h100);

      run_op(1'b1, F3_W, 32'h106, 32'hCAFEF00D, 32'h0, 0, 0);
`ifdef MISALIGN_TRAP_EN
      check("sw_mis_hs", hs, 0);
      check("sw_mis_cycles", dc, 2);
      check("sw_mis_flag", mis, 1'b1);
      check("sw_mis_rdata", res, 32'h0);
`else
      check("sw_mis_addr", ha, 32'h104);
      check("sw_mis_wstrb", hst, 4'b1111);
      check("sw_mis_wdata", hwd, 32'hCAFEF00D);
      check("sw_mis_cycles", dc, 3);
      check("sw_mis_flag", mis, 1'b0);
`endif

      run_op(1'b0, F3_H, 32'h103, 32'h0, 32'h80017FFF, 0, 0);
`ifdef MISALIGN_TRAP_EN
      check("lh_mis_hs", hs, 0);
      check("lh_mis_cycles", dc, 2);
      check("lh_mis_flag", mis, 1'b1);
      check("lh_mis_rdata", res, 32'h0);
`else
      check("lh_mis_data", res, 32'hFFFF8001);
      check("lh_mis_cycles", dc, 4);
      check("lh_mis_flag", mis, 1'b0);
`endif

      // undefined funct3 stores as a word
      run_op(1'b1, 3'b011, 32'h10, 32'h0BADF00D, 32'h0, 0, 0);
      check("undef_wstrb", hst, 4'b1111);
      check("undef_wdata", hwd, 32'h0BADF00D);

      // back-to-back LW then SW with req_i held high throughout
      run_op(1'b0, F3_W, 32'h20, 32'h0, 32'h11223344, 0, 0);
      check("b2b_lw_data", res, 32'h11223344);
      check("b2b_lw_hs", hs, 1);
      run_op(1'b1, F3_W, 32'h24, 32'h55667788, 32'h0, 0, 0);
      check("b2b_sw_hs", hs, 1);
      check("b2b_sw_cycles", dc, 3);
      check("b2b_sw_addr", ha, 32'h24);
      req_i = 1'b0;
      check("rdata_hold", rdata_o, 32'h11223344);
      @(negedge clock); #1;
      check("b2b_no_dup", bus_valid_o, 1'b0);

      // reset while waiting for read data, then a late rvalid
      req_i = 1'b1; we_i = 1'b0; funct3_i = F3_W; addr_i = 32'h300;
      bus_rdata_i = 32'hAAAA5555;
      @(negedge clock); #1;
      check("rst_mid_req", bus_valid_o, 1'b1);
      bus_ready_i = 1'b1;
      @(negedge clock);
      bus_ready_i = 1'b0;
      #1;
      check("rst_mid_wait", dut.state_q, ST_WAIT_R);
      reset = 1'b1; req_i = 1'b0;
      @(negedge clock);
      reset = 1'b0; bus_rvalid_i = 1'b1;
      #1;
      check("rst_mid_valid", bus_valid_o, 1'b0);
      check("rst_mid_done", done_o, 1'b0);
      @(negedge clock);
      bus_rvalid_i = 1'b0;
      #1;
      check("rst_mid_state", dut.state_q, ST_IDLE);
      check("rst_mid_done2", done_o, 1'b0);
      check("rst_mid_rdata", rdata_o, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
